// File: rtl/gpu_command_issuer.sv
// gpu_command_issuer
//   CPU-side producer for the GPU 32-bit instruction bus. Draw commands
//   written by the core are queued in a FIFO. They are then presented one at
//   a time on INSTRUCTION. Each command is held for DRAW_CYCLES cycles, and
//   only while REFRESH is low. NOP_WORD is driven whenever no command is
//   being issued.
//
//   Optional feature macro: GPU_CMD_OVERFLOW_EN
//     When defined, a sticky OVERFLOW output is added. It is set by a write
//     while FULL. It is cleared by reset, or by writing the reserved word
//     32'hFFFF_FFFF, which is not queued.
//     When undefined, there is no OVERFLOW port, 32'hFFFF_FFFF is queued like
//     any other word, and writes while FULL are dropped silently.
//
// Ports
//   CLK          system clock
//   RST          asynchronous active-low reset
//   WE           command register store strobe (one cycle per command)
//   WDATA        command word {Y[10],X[10],OP[3],SPRITE_ID[9]}
//   REFRESH      GPU V_SYNC; high = pixel array not writable
//   INSTRUCTION  word presented to the GPU (registered)
//   BUSY         a command is in flight or the FIFO is non-empty
//   FULL         FIFO holds DEPTH entries
//   LEVEL        FIFO occupancy
//   OVERFLOW     sticky dropped-write flag (GPU_CMD_OVERFLOW_EN only)
module gpu_command_issuer #(
    parameter int          DEPTH       = 16,
    parameter int          DRAW_CYCLES = 1024,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     WE,
    input  logic [31:0]              WDATA,
    input  logic                     REFRESH,
    output logic [31:0]              INSTRUCTION,
    output logic                     BUSY,
    output logic                     FULL,
`ifdef GPU_CMD_OVERFLOW_EN
    output logic                     OVERFLOW,
`endif
    output logic [$clog2(DEPTH):0]   LEVEL
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DRAW_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAW_CYCLES - 1);
    localparam logic [PTR_W:0]   LEVEL_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        cur_cmd;
    logic               push;
    logic               pop;
    logic               clear_cmd;

`ifdef GPU_CMD_OVERFLOW_EN
    // The reserved all-ones word is a flag-clear request, never a command.
    assign clear_cmd = WE && (WDATA == 32'hFFFF_FFFF);
`else
    assign clear_cmd = 1'b0;
`endif

    assign FULL = (LEVEL == LEVEL_FULL);
    assign BUSY = (state != IDLE) || (LEVEL != '0);
    assign push = WE && !FULL && !clear_cmd;
    // The pop looks only at the registered LEVEL, so a word pushed into an
    // empty FIFO cannot be popped until the following cycle.
    assign pop  = (state == IDLE) && (LEVEL != '0) && !REFRESH;

    // FIFO storage and current-command copy (data only, no reset)
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= WDATA;
        if (pop)
            cur_cmd <= mem[rd_ptr];
    end

    // FIFO control
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            LEVEL  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   LEVEL <= LEVEL + 1'b1;
                2'b01:   LEVEL <= LEVEL - 1'b1;
                default: LEVEL <= LEVEL;
            endcase
        end
    end

    // Issue FSM with registered INSTRUCTION
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            cnt         <= '0;
            INSTRUCTION <= NOP_WORD;
        end else begin
            case (state)
                IDLE: begin
                    INSTRUCTION <= NOP_WORD;
                    if (pop) begin
                        state       <= ISSUE;
                        cnt         <= '0;
                        INSTRUCTION <= mem[rd_ptr];
                    end
                end
                ISSUE: begin
                    // Completion wins over a simultaneous REFRESH rise: the
                    // command has already been shown for its full interval.
                    if (cnt == CNT_LAST) begin
                        state       <= IDLE;
                        INSTRUCTION <= NOP_WORD;
                    end else if (REFRESH) begin
                        state       <= HOLD;
                        cnt         <= '0;
                        INSTRUCTION <= NOP_WORD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    INSTRUCTION <= NOP_WORD;
                    // An interrupted draw restarts from scratch so the
                    // sprite is fully redrawn.
                    if (!REFRESH) begin
                        state       <= ISSUE;
                        cnt         <= '0;
                        INSTRUCTION <= cur_cmd;
                    end
                end
                default: begin
                    state       <= IDLE;
                    INSTRUCTION <= NOP_WORD;
                end
            endcase
        end
    end

`ifdef GPU_CMD_OVERFLOW_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            OVERFLOW <= 1'b0;
        else if (clear_cmd)
            OVERFLOW <= 1'b0;
        else if (WE && FULL)
            OVERFLOW <= 1'b1;
    end
`endif

endmodule

// File: doc/gpu_command_issuer.md
Name: gpu_command_issuer

Overview:
CPU-side producer for the GPU 32-bit instruction bus.
- Accepts draw commands from the ARMv4 core through memory-mapped stores and buffers them in a FIFO.
- Presents one command at a time on INSTRUCTION. Each command is held stable for a full sprite-draw interval.
- Draws only while the GPU's REFRESH (V_SYNC) is low, which is when the pixel array is writable.
- Drives a NOP word whenever it has nothing to issue.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
- DRAW_CYCLES, 1024, cycles each command is held (32x32 sprite scan).
- NOP_WORD, 32'h0000_0000, word driven when idle (OP field = 3'b000).

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous active-low reset.
- WE  input  1  CPU store strobe for the command register, one cycle per command.
- WDATA  input  32  command word {Y[10],X[10],OP[3],SPRITE_ID[9]}.
- REFRESH  input  1  GPU V_SYNC/REFRESH; high means the pixel array is not writable.
- INSTRUCTION  output  32  word presented to the GPU.
- BUSY  output  1  a command is in flight or the FIFO is non-empty.
- FULL  output  1  FIFO holds DEPTH entries.
- LEVEL  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (RST=0, asynchronous) values:
  - INSTRUCTION=NOP_WORD, BUSY=0, FULL=0, LEVEL=0.
  - FIFO pointers cleared, hold counter cleared, state=IDLE.
  - Reset mid-command drops the command; no partial-state recovery.
- FIFO write:
  - WE=1 with FULL=0 pushes WDATA on the rising edge.
  - WE=1 with FULL=1 drops the word; FIFO contents are unchanged.
- FIFO read: pops only on the IDLE->ISSUE transition.
  - A push and a pop in the same cycle leave LEVEL unchanged.
  - A push into an empty FIFO is not visible to the pop logic until the next cycle; no bypass.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. FULL and empty come from LEVEL.
- State machine, registered outputs:
  - IDLE: INSTRUCTION=NOP_WORD.
    - If FIFO non-empty and REFRESH=0: pop head into the current-command register, counter=0, go to ISSUE.
    - INSTRUCTION shows the command on the following cycle, one cycle after the pop.
  - ISSUE: INSTRUCTION=current command; counter increments each cycle.
    - Counter reaching DRAW_CYCLES-1 -> IDLE. A back-to-back pop in that same cycle is not allowed, so there is exactly one NOP cycle between commands.
    - REFRESH=1 -> HOLD, counter=0.
  - HOLD: INSTRUCTION=NOP_WORD.
    - REFRESH falling back to 0 -> ISSUE with the same command and counter restarted, giving a full redraw.
- Commands with OP=3'b000 (NOP) are still queued and issued for the full DRAW_CYCLES. The block does not filter them.
- BUSY = (state!=IDLE) | (LEVEL!=0).
- The counter is $clog2(DRAW_CYCLES)+1 bits and never wraps during ISSUE.
- If REFRESH is high in IDLE, nothing is popped; commands wait in the FIFO.

Optional Feature:
GPU_CMD_OVERFLOW_EN
- Defined: adds output OVERFLOW (1 bit).
  - Set, sticky, on any cycle with WE=1 and FULL=1.
  - Cleared only by reset, or by WE=1 with WDATA=32'hFFFF_FFFF, a reserved clear command that is not queued.
- Undefined: no OVERFLOW port. 32'hFFFF_FFFF is queued like any other word, and dropped writes are silent.

Test Plan:
1. Reset release, REFRESH=0, no writes -> INSTRUCTION=32'h0 and BUSY=0 for 100 cycles.
2. One write WDATA=32'h0A01_4205, REFRESH=0 ->
   - LEVEL=1, then 0 after the pop.
   - INSTRUCTION=32'h0A01_4205 for exactly 1024 cycles, then NOP; BUSY falls with the return to NOP.
3. DEPTH=16: write 17 words while REFRESH=1 ->
   - FULL=1 and LEVEL=16; 17th word dropped.
   - With GPU_CMD_OVERFLOW_EN, OVERFLOW=1.
   - Release REFRESH -> 16 words issued in write order, each for 1024 cycles, with 1 NOP cycle between.
4. Raise REFRESH at cycle 500 of a command ->
   - INSTRUCTION=NOP during HOLD.
   - After REFRESH falls, the same command is re-held for a full 1024 cycles; LEVEL unchanged.
5. WE on the same cycle as the IDLE->ISSUE pop with LEVEL=3 -> LEVEL stays 3; write order preserved.
6. Assert RST=0 asynchronously mid-ISSUE (between clock edges) -> INSTRUCTION=NOP and LEVEL=0 immediately; after release, no stale command is issued.
